// File: rtl/cc_busmux_pipe_if.sv
// rtl/cc_busmux_pipe_if.sv - request/result bundle for the pipelined channel bus multiplexer
//
// Purpose: groups the channel bus, selectors and both handshakes of cc_busmux_pipe.
// Ports (signals):
//   CC_BUSMUX_PIPE_data_InBus                [NUM_CHANNELS*DATAWIDTH_BUS]  flat channel bus
//   CC_BUSMUX_PIPE_Select_In                 0 = scratchpad selector, 1 = MIR selector
//   CC_BUSMUX_PIPE_ScratchpadSelection_InBus scratchpad channel index
//   CC_BUSMUX_PIPE_MIRSelection_InBus        MIR channel index
//   CC_BUSMUX_PIPE_Valid_In / Ready_Out      upstream request handshake
//   CC_BUSMUX_PIPE_data_OutBus               registered selected data
//   CC_BUSMUX_PIPE_Channel_OutBus            registered effective channel index
//   CC_BUSMUX_PIPE_Valid_Out / Ready_In      downstream result handshake
//   CC_BUSMUX_PIPE_RangeError_Out            sticky out-of-range flag
//   CC_BUSMUX_PIPE_ErrorClear_In             clear for the sticky flag
// Modports: master = upstream/downstream side, slave = the multiplexer.
interface cc_busmux_pipe_if #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int NUM_CHANNELS                   = 16,
  parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int DATAWIDTH_MIR_DIRECTION        = 6
);
  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0]       CC_BUSMUX_PIPE_data_InBus;
  logic                                        CC_BUSMUX_PIPE_Select_In;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0]   CC_BUSMUX_PIPE_ScratchpadSelection_InBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0]          CC_BUSMUX_PIPE_MIRSelection_InBus;
  logic                                        CC_BUSMUX_PIPE_Valid_In;
  logic                                        CC_BUSMUX_PIPE_Ready_Out;
  logic [DATAWIDTH_BUS-1:0]                    CC_BUSMUX_PIPE_data_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0]          CC_BUSMUX_PIPE_Channel_OutBus;
  logic                                        CC_BUSMUX_PIPE_Valid_Out;
  logic                                        CC_BUSMUX_PIPE_Ready_In;
  logic                                        CC_BUSMUX_PIPE_RangeError_Out;
  logic                                        CC_BUSMUX_PIPE_ErrorClear_In;

  modport master (
    output CC_BUSMUX_PIPE_data_InBus, CC_BUSMUX_PIPE_Select_In,
           CC_BUSMUX_PIPE_ScratchpadSelection_InBus, CC_BUSMUX_PIPE_MIRSelection_InBus,
           CC_BUSMUX_PIPE_Valid_In, CC_BUSMUX_PIPE_Ready_In, CC_BUSMUX_PIPE_ErrorClear_In,
    input  CC_BUSMUX_PIPE_Ready_Out, CC_BUSMUX_PIPE_data_OutBus, CC_BUSMUX_PIPE_Channel_OutBus,
           CC_BUSMUX_PIPE_Valid_Out, CC_BUSMUX_PIPE_RangeError_Out
  );

  modport slave (
    input  CC_BUSMUX_PIPE_data_InBus, CC_BUSMUX_PIPE_Select_In,
           CC_BUSMUX_PIPE_ScratchpadSelection_InBus, CC_BUSMUX_PIPE_MIRSelection_InBus,
           CC_BUSMUX_PIPE_Valid_In, CC_BUSMUX_PIPE_Ready_In, CC_BUSMUX_PIPE_ErrorClear_In,
    output CC_BUSMUX_PIPE_Ready_Out, CC_BUSMUX_PIPE_data_OutBus, CC_BUSMUX_PIPE_Channel_OutBus,
           CC_BUSMUX_PIPE_Valid_Out, CC_BUSMUX_PIPE_RangeError_Out
  );
endinterface

// File: rtl/cc_busmux_pipe.sv
// rtl/cc_busmux_pipe.sv - one-stage pipelined channel multiplexer with range checking
//
// Purpose: selects one channel of a flat bus by a scratchpad or MIR index, registers
// the data and the effective index behind a valid/ready handshake, and flags
// out-of-range indices (which fall back to channel 0) in a sticky error bit.
// Ports:
//   CC_BUSMUX_PIPE_CLOCK_50      rising-edge clock
//   CC_BUSMUX_PIPE_RESET_InHigh  asynchronous active-high reset
//   busIf                        cc_busmux_pipe_if.slave (bus, selectors, handshakes, error)
module cc_busmux_pipe #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int NUM_CHANNELS                   = 16,
  parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int DATAWIDTH_MIR_DIRECTION        = 6
) (
  input  logic          CC_BUSMUX_PIPE_CLOCK_50,
  input  logic          CC_BUSMUX_PIPE_RESET_InHigh,
  cc_busmux_pipe_if.slave busIf
);

  typedef enum logic {sEmpty, sFull} stateType;

  stateType                           state, stateNext;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] rawIndex;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] effIndex;
  logic                               outOfRange;
  logic                               readyOut;
  logic                               accept;
  logic [DATAWIDTH_BUS-1:0]           selData;
  logic [DATAWIDTH_BUS-1:0]           dataReg;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] channelReg;
  logic                               rangeErr;

  // Scratchpad selector is zero-extended into the wider MIR index space.
  always_comb begin
    rawIndex = '0;
    if (busIf.CC_BUSMUX_PIPE_Select_In)
      rawIndex = busIf.CC_BUSMUX_PIPE_MIRSelection_InBus;
    else
      rawIndex[DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] = busIf.CC_BUSMUX_PIPE_ScratchpadSelection_InBus;
  end

  assign outOfRange = 32'(rawIndex) >= 32'(NUM_CHANNELS);
  assign effIndex   = outOfRange ? '0 : rawIndex;

  // Compare-and-select mux keeps index widths independent of NUM_CHANNELS.
  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (32'(effIndex) == 32'(k))
        selData = busIf.CC_BUSMUX_PIPE_data_InBus[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  end

  // A full stage can still accept when the result leaves in the same cycle.
  assign readyOut = (state == sEmpty) || busIf.CC_BUSMUX_PIPE_Ready_In;
  assign accept   = busIf.CC_BUSMUX_PIPE_Valid_In && readyOut;

  always_ff @(posedge CC_BUSMUX_PIPE_CLOCK_50 or posedge CC_BUSMUX_PIPE_RESET_InHigh) begin
    if (CC_BUSMUX_PIPE_RESET_InHigh)
      state <= sEmpty;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      sEmpty: if (busIf.CC_BUSMUX_PIPE_Valid_In) stateNext = sFull;
      sFull:  if (busIf.CC_BUSMUX_PIPE_Ready_In && !busIf.CC_BUSMUX_PIPE_Valid_In) stateNext = sEmpty;
      default: stateNext = sEmpty;
    endcase
  end

  always_ff @(posedge CC_BUSMUX_PIPE_CLOCK_50 or posedge CC_BUSMUX_PIPE_RESET_InHigh) begin
    if (CC_BUSMUX_PIPE_RESET_InHigh) begin
      dataReg    <= '0;
      channelReg <= '0;
    end else if (accept) begin
      dataReg    <= selData;
      channelReg <= effIndex;
    end
  end

  // Setting has priority over clearing so a coincident error is never lost.
  always_ff @(posedge CC_BUSMUX_PIPE_CLOCK_50 or posedge CC_BUSMUX_PIPE_RESET_InHigh) begin
    if (CC_BUSMUX_PIPE_RESET_InHigh)
      rangeErr <= 1'b0;
    else if (accept && outOfRange)
      rangeErr <= 1'b1;
    else if (busIf.CC_BUSMUX_PIPE_ErrorClear_In)
      rangeErr <= 1'b0;
  end

  assign busIf.CC_BUSMUX_PIPE_Ready_Out      = readyOut;
  assign busIf.CC_BUSMUX_PIPE_data_OutBus    = dataReg;
  assign busIf.CC_BUSMUX_PIPE_Channel_OutBus = channelReg;
  assign busIf.CC_BUSMUX_PIPE_Valid_Out      = (state == sFull);
  assign busIf.CC_BUSMUX_PIPE_RangeError_Out = rangeErr;

endmodule

// File: tb/tb_cc_busmux_pipe.sv
// tb/tb_cc_busmux_pipe.sv - directed and randomized bench for cc_busmux_pipe
module tb_cc_busmux_pipe;
  localparam int DW   = 32;
  localparam int NCH  = 16;
  localparam int SPW  = 5;
  localparam int MIRW = 6;

  logic clk;
  logic rst;

  cc_busmux_pipe_if #(
    .DATAWIDTH_BUS(DW), .NUM_CHANNELS(NCH),
    .DATAWIDTH_SCRATCHPAD_DIRECTION(SPW), .DATAWIDTH_MIR_DIRECTION(MIRW)
  ) busIf ();

  cc_busmux_pipe #(
    .DATAWIDTH_BUS(DW), .NUM_CHANNELS(NCH),
    .DATAWIDTH_SCRATCHPAD_DIRECTION(SPW), .DATAWIDTH_MIR_DIRECTION(MIRW)
  ) dut (
    .CC_BUSMUX_PIPE_CLOCK_50(clk),
    .CC_BUSMUX_PIPE_RESET_InHigh(rst),
    .busIf(busIf.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic [DW-1:0]   chan [NCH];
  logic            sel;
  logic [SPW-1:0]  sp;
  logic [MIRW-1:0] mir;
  logic            validIn, readyIn, clr;

  // Reference model: the single result slot as seen from outside
  logic [DW-1:0] mData;
  int            mChan;
  logic          mValid;
  logic          mErr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyInputs();
    for (int k = 0; k < NCH; k++)
      busIf.CC_BUSMUX_PIPE_data_InBus[k*DW +: DW] = chan[k];
    busIf.CC_BUSMUX_PIPE_Select_In                = sel;
    busIf.CC_BUSMUX_PIPE_ScratchpadSelection_InBus = sp;
    busIf.CC_BUSMUX_PIPE_MIRSelection_InBus       = mir;
    busIf.CC_BUSMUX_PIPE_Valid_In                 = validIn;
    busIf.CC_BUSMUX_PIPE_Ready_In                 = readyIn;
    busIf.CC_BUSMUX_PIPE_ErrorClear_In            = clr;
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".data"},  busIf.CC_BUSMUX_PIPE_data_OutBus,    mData);
    chk({tag, ".chan"},  busIf.CC_BUSMUX_PIPE_Channel_OutBus, 64'(mChan));
    chk({tag, ".valid"}, busIf.CC_BUSMUX_PIPE_Valid_Out,      mValid);
    chk({tag, ".err"},   busIf.CC_BUSMUX_PIPE_RangeError_Out, mErr);
    chk({tag, ".ready"}, busIf.CC_BUSMUX_PIPE_Ready_Out,      (!mValid) || readyIn);
  endtask

  // Drive current inputs, predict the edge from the handshake rules, clock, compare.
  task automatic step(input string tag);
    int   raw, eff;
    logic oor, acc;
    applyInputs();
    #1;
    chk({tag, ".readyPre"}, busIf.CC_BUSMUX_PIPE_Ready_Out, (!mValid) || readyIn);
    raw = sel ? int'(mir) : int'(sp);
    oor = (raw >= NCH);
    eff = oor ? 0 : raw;
    acc = validIn && ((!mValid) || readyIn);
    if (acc) begin
      mData  = chan[eff];
      mChan  = eff;
      mValid = 1'b1;
    end else if (mValid && readyIn) begin
      mValid = 1'b0;
    end
    if (acc && oor) mErr = 1'b1;
    else if (clr)   mErr = 1'b0;
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic modelReset();
    mData = '0; mChan = 0; mValid = 1'b0; mErr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) chan[k] = 32'hC0DE_0000 + 32'(k);
    sel = 0; sp = '0; mir = '0; validIn = 0; readyIn = 0; clr = 0;
    rst = 1'b1;
    applyInputs();
    modelReset();
    #1;
    checkAll("reset");

    // No accept while reset is held, even with a valid request
    validIn = 1; readyIn = 1;
    applyInputs();
    @(posedge clk); #1;
    checkAll("resetHold");
    @(posedge clk); #1;
    rst = 1'b0;

    // Scratchpad index 5
    sel = 0; sp = 5; chan[5] = 32'hA5A5_0005; validIn = 1; readyIn = 1;
    step("sp5");

    // MIR index 20 is out of range -> channel 0, sticky error
    sel = 1; mir = 6'd20; chan[0] = 32'h1234_5678;
    step("mir20");
    validIn = 0; clr = 1;
    step("clrPulse");
    clr = 0;
    step("clrDone");

    // Boundaries: last valid, first invalid, max MIR, max scratchpad
    validIn = 1;
    sel = 1; mir = 6'd15; step("mir15");
    sel = 1; mir = 6'd16; step("mir16");
    sel = 1; mir = 6'd63; clr = 1; step("mir63SetWins");
    clr = 0;
    sel = 0; sp = 5'd31; step("sp31");
    clr = 1; validIn = 0; step("clr2");
    clr = 0;

    // Stall: result held 4 cycles while everything else moves
    validIn = 1; sel = 0; sp = 3; chan[3] = 32'hDEAD_0003; readyIn = 1;
    step("stallLoad");
    readyIn = 0;
    for (int i = 0; i < 4; i++) begin
      chan[3] = $urandom; sp = 5'($urandom_range(0, 31)); sel = 1'($urandom_range(0, 1));
      mir = 6'($urandom_range(0, 63));
      step("stall");
    end
    readyIn = 1; validIn = 0;
    step("stallRelease");

    // Back-to-back indices 0..7, no bubbles
    readyIn = 1; validIn = 1; sel = 0;
    for (int i = 0; i < 8; i++) begin
      chan[i] = 32'hB0B0_0000 + 32'(i * 17);
      sp = 5'(i);
      step("stream");
    end

    // Reset in the middle of a stall
    sp = 9; chan[9] = 32'h9999_0009; readyIn = 1; validIn = 1;
    step("preRst");
    readyIn = 0;
    step("stallRst");
    #4;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("rstAsync");
    @(posedge clk); #1;
    checkAll("rstHeld");
    rst = 1'b0;
    readyIn = 1; sp = 2; chan[2] = 32'h2222_0002;
    step("postRst");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NCH; k++) chan[k] = $urandom;
      sel     = 1'($urandom_range(0, 1));
      sp      = 5'($urandom_range(0, 31));
      mir     = 6'($urandom_range(0, 63));
      validIn = ($urandom_range(0, 3) != 0);
      readyIn = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_busmux_pipe.md
CC_BUSMUX_PIPE -- requirements
Module: CC_BUSMUX_PIPE

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, SHALL set the width of each data channel.
REQ-002 Parameter NUM_CHANNELS, default 16, range 2..64, SHALL set the number of input channels.
REQ-003 Parameter DATAWIDTH_SCRATCHPAD_DIRECTION, default 5, SHALL set the scratchpad selector width.
REQ-004 Parameter DATAWIDTH_MIR_DIRECTION, default 6, SHALL set the MIR selector width; it SHALL be >= DATAWIDTH_SCRATCHPAD_DIRECTION.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-006 CC_BUSMUX_PIPE_CLOCK_50  in  1  rising-edge clock.
REQ-007 CC_BUSMUX_PIPE_RESET_InHigh  in  1  asynchronous active-high reset.
REQ-008 CC_BUSMUX_PIPE_data_InBus  in  NUM_CHANNELS*DATAWIDTH_BUS  flat channel bus; channel k = bits [k*DATAWIDTH_BUS +: DATAWIDTH_BUS].
REQ-009 CC_BUSMUX_PIPE_Select_In  in  1  0 = scratchpad selector, 1 = MIR selector.
REQ-010 CC_BUSMUX_PIPE_ScratchpadSelection_InBus  in  DATAWIDTH_SCRATCHPAD_DIRECTION  scratchpad channel index.
REQ-011 CC_BUSMUX_PIPE_MIRSelection_InBus  in  DATAWIDTH_MIR_DIRECTION  MIR channel index.
REQ-012 CC_BUSMUX_PIPE_Valid_In  in  1  upstream request valid.
REQ-013 CC_BUSMUX_PIPE_Ready_Out  out  1  block can accept a request this cycle.
REQ-014 CC_BUSMUX_PIPE_data_OutBus  out  DATAWIDTH_BUS  registered selected data.
REQ-015 CC_BUSMUX_PIPE_Channel_OutBus  out  DATAWIDTH_MIR_DIRECTION  registered effective channel index.
REQ-016 CC_BUSMUX_PIPE_Valid_Out  out  1  output register holds an unconsumed result.
REQ-017 CC_BUSMUX_PIPE_Ready_In  in  1  downstream consumes the result.
REQ-018 CC_BUSMUX_PIPE_RangeError_Out  out  1  sticky out-of-range flag.
REQ-019 CC_BUSMUX_PIPE_ErrorClear_In  in  1  synchronous clear of RangeError_Out.

Function
REQ-020 Raw index SHALL be the scratchpad selector zero-extended to DATAWIDTH_MIR_DIRECTION bits when Select_In=0, else the MIR selector.
REQ-021 Raw index >= NUM_CHANNELS SHALL be out of range; effective index then SHALL be 0, otherwise equal to raw index.
REQ-022 Ready_Out SHALL equal (!Valid_Out || Ready_In), combinationally.
REQ-023 Accept SHALL occur on a rising edge with Valid_In=1 and Ready_Out=1.
REQ-024 On accept, data_OutBus SHALL load channel[effective index], Channel_OutBus SHALL load effective index, and Valid_Out SHALL be 1 the next cycle (latency 1).
REQ-025 On a consume edge (Valid_Out=1, Ready_In=1) with no accept, Valid_Out SHALL go 0; data_OutBus and Channel_OutBus SHALL hold.
REQ-026 Simultaneous consume and accept SHALL load the new result with Valid_Out staying 1 (full throughput, one result per cycle).
REQ-027 While Valid_Out=1 and Ready_In=0 (stall), data_OutBus, Channel_OutBus and Valid_Out SHALL hold regardless of Valid_In, selectors or channel data.
REQ-028 An accept with an out-of-range raw index SHALL set RangeError_Out at that edge; out-of-range indices without accept SHALL NOT set it.
REQ-029 ErrorClear_In=1 SHALL clear RangeError_Out on the next edge; set SHALL win when an out-of-range accept coincides with clear.
REQ-030 Selected data SHALL be sampled at the accept edge; later channel changes SHALL NOT affect the held result.

Reset
REQ-031 Reset assertion SHALL immediately force data_OutBus=0, Channel_OutBus=0, Valid_Out=0 and RangeError_Out=0, without waiting for a clock edge.
REQ-032 Ready_Out SHALL be 1 during and after reset (since Valid_Out=0).
REQ-033 A result pending when reset asserts SHALL be discarded; no accept SHALL occur while reset is high.

Verification
REQ-034 Reset, then Select_In=0, scratchpad=5, channel5=0xA5A5_0005, Valid_In=1, Ready_In=1 -> next cycle data_OutBus=0xA5A5_0005, Channel_OutBus=5, Valid_Out=1.
REQ-035 Select_In=1, MIR=6'd20 (NUM_CHANNELS=16), channel0=0x1234_5678, accept -> data_OutBus=0x1234_5678, Channel_OutBus=0, RangeError_Out=1; one ErrorClear_In pulse -> 0.
REQ-036 Hold Ready_In=0 for 4 cycles after an accept while changing channel data and selectors -> outputs unchanged, Ready_Out=0; Ready_In=1 -> consumed.
REQ-037 Valid_In=1 and Ready_In=1 for 8 cycles with indices 0..7 -> 8 consecutive results, in order, with no bubbles.
REQ-038 Assert reset mid-stall with Valid_Out=1 -> Valid_Out=0, data_OutBus=0 immediately; first accept after release -> normal result.
